// File: rtl/tone_sample_gen_if.sv
// tone_sample_gen_if: control and sample bus of the tone sample generator.
//   master: distance logic / DAC side (drives tone controls, receives samples)
//   slave : tone_sample_gen
//   enable_i, freq_word_i, amplitude_i, beep_period_i, beep_on_i : tone controls
//   sample_l_o, sample_r_o, sample_ready_o                       : sample stream
interface tone_sample_gen_if;
  logic        enable_i;
  logic [23:0] freq_word_i;
  logic [7:0]  amplitude_i;
  logic [15:0] beep_period_i;
  logic [15:0] beep_on_i;
  logic [23:0] sample_l_o;
  logic [23:0] sample_r_o;
  logic        sample_ready_o;

  modport master (
    output enable_i, freq_word_i, amplitude_i, beep_period_i, beep_on_i,
    input  sample_l_o, sample_r_o, sample_ready_o
  );

  modport slave (
    input  enable_i, freq_word_i, amplitude_i, beep_period_i, beep_on_i,
    output sample_l_o, sample_r_o, sample_ready_o
  );
endinterface

// File: rtl/tone_sample_gen.sv
// tone_sample_gen: beeping tone source feeding the I2S DAC driver.
//   Phase accumulator tone, gated into beeps of beep_period_i samples with
//   beep_on_i sounding samples each; one signed 24-bit sample pair (L == R)
//   per CLK_PER_SAMPLE clocks with a one-cycle sample_ready_o strobe.
// Ports:
//   clk_i   : clock, rising edge
//   reset_i : asynchronous active-high reset
//   bus     : tone_sample_gen_if.slave (controls in, samples out)
// Configuration:
//   TONE_GEN_TRIANGLE_EN defined   -> triangle wave (one multiplier)
//   TONE_GEN_TRIANGLE_EN undefined -> square wave, no multiplier
module tone_sample_gen #(
  parameter int CLK_PER_SAMPLE = 384,
  parameter int PHASE_W        = 24
) (
  input  logic              clk_i,
  input  logic              reset_i,
  tone_sample_gen_if.slave  bus
);

  localparam int DIV_W = $clog2(CLK_PER_SAMPLE);

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state_q, state_d;
  logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
  logic [PHASE_W-1:0]   phase_q, phase_d;
  logic [15:0]          beep_cnt_q, beep_cnt_d;
  logic [23:0]          sample_q, sample_d;
  logic                 ready_q, ready_d;
  logic                 tick;
  logic                 sound;
  logic [23:0]          wave;

  assign tick = (div_cnt_q == DIV_W'(CLK_PER_SAMPLE - 1));

  // Waveform of the current (pre-increment) phase.
`ifdef TONE_GEN_TRIANGLE_EN
  logic [22:0]        tri_t;
  logic signed [23:0] tri_c;
  logic signed [8:0]  amp_s;
  logic signed [32:0] prod;
  logic               prod_unused;

  always_comb begin
    tri_t = phase_q[22:0] ^ {23{phase_q[23]}};
    // Centre the 0..2^23-1 ramp around zero: -2^22..2^22-1.
    tri_c = $signed({1'b0, tri_t}) - 24'sd4194304;
    amp_s = $signed({1'b0, bus.amplitude_i});
    prod  = tri_c * amp_s;
    // >>> 7 then truncate; |prod| < 2^30 so bits 30:7 hold the full result.
    wave  = prod[30:7];
  end
  assign prod_unused = ^{prod[32:31], prod[6:0]};
`else
  logic [23:0] amp_word;

  always_comb begin
    amp_word = {1'b0, bus.amplitude_i, 15'b0};
    wave     = phase_q[23] ? (24'd0 - amp_word) : amp_word;
  end
`endif

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    beep_cnt_d = beep_cnt_q;
    sample_d   = sample_q;
    sound      = 1'b0;
    ready_d    = tick;
    div_cnt_d  = tick ? '0 : div_cnt_q + 1'b1;

    if (tick) begin
      unique case (state_q)
        IDLE: begin
          sample_d   = '0;
          phase_d    = '0;
          beep_cnt_d = '0;
          if (bus.enable_i) state_d = RUN;
        end
        RUN: begin
          if (!bus.enable_i) begin
            state_d    = IDLE;
            sample_d   = '0;
            phase_d    = '0;
            beep_cnt_d = '0;
          end else begin
            sound    = (bus.beep_period_i == 16'd0) ||
                       (beep_cnt_q < bus.beep_on_i);
            sample_d = sound ? wave : 24'd0;
            phase_d  = phase_q + bus.freq_word_i;
            if (bus.beep_period_i == 16'd0) begin
              beep_cnt_d = '0;
            end else if (beep_cnt_q >= bus.beep_period_i - 16'd1) begin
              // New beep: restart phase so every beep opens on the same edge.
              beep_cnt_d = '0;
              phase_d    = '0;
            end else begin
              beep_cnt_d = beep_cnt_q + 16'd1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      div_cnt_q  <= '0;
      phase_q    <= '0;
      beep_cnt_q <= '0;
      sample_q   <= '0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      phase_q    <= phase_d;
      beep_cnt_q <= beep_cnt_d;
      sample_q   <= sample_d;
      ready_q    <= ready_d;
    end
  end

  assign bus.sample_l_o     = sample_q;
  assign bus.sample_r_o     = sample_q;
  assign bus.sample_ready_o = ready_q;

endmodule

// File: tb/tb_tone_sample_gen.sv
// tb_tone_sample_gen: directed, table-driven bench for tone_sample_gen
// with CLK_PER_SAMPLE = 8. Each table row sets the controls just after a
// strobe and gives the sample expected on the following strobe.
module tb_tone_sample_gen;

  localparam int N = 8;
  localparam logic [23:0] PA = 24'h400000;  // +A for amplitude 0x80
  localparam logic [23:0] NA = 24'hC00000;  // -A for amplitude 0x80

  logic clk_i = 1'b0;
  logic reset_i = 1'b1;
  tone_sample_gen_if bus ();

  tone_sample_gen #(.CLK_PER_SAMPLE(N), .PHASE_W(24)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .bus     (bus.slave)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        en;
    logic [23:0] freq;
    logic [7:0]  amp;
    logic [15:0] per;
    logic [15:0] bon;
    logic [23:0] exp;
  } vec_t;

  vec_t vecs[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic void add(logic en, logic [23:0] freq, logic [7:0] amp,
                              logic [15:0] per, logic [15:0] bon,
                              logic [23:0] exp);
    vec_t v;
    v.en = en; v.freq = freq; v.amp = amp; v.per = per; v.bon = bon; v.exp = exp;
    vecs.push_back(v);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Wait for the next strobe (bounded); cycles = clock edges waited.
  // Also verifies the sample held steady between strobes.
  task automatic wait_strobe(output int cycles);
    logic [23:0] prev;
    logic        moved;
    prev   = bus.sample_l_o;
    moved  = 1'b0;
    cycles = 0;
    while (cycles < 4 * N) begin
      @(posedge clk_i);
      @(negedge clk_i);
      cycles++;
      if (bus.sample_ready_o === 1'b1) break;
      if (bus.sample_l_o !== prev) moved = 1'b1;
    end
    check("strobe_timeout", 32'(bus.sample_ready_o), 32'd1);
    check("hold_between_strobes", 32'(moved), 32'd0);
  endtask

  task automatic drive(vec_t v);
    bus.enable_i      = v.en;
    bus.freq_word_i   = v.freq;
    bus.amplitude_i   = v.amp;
    bus.beep_period_i = v.per;
    bus.beep_on_i     = v.bon;
  endtask

  initial begin
    int c;
    vec_t v;
    logic [23:0] rst_exp2;

`ifdef TONE_GEN_TRIANGLE_EN
    add(1, 24'h200000, 8'h80, 0, 0, 24'h000000);  // IDLE->RUN
    add(1, 24'h200000, 8'h80, 0, 0, 24'hC00000);  // phase 0
    add(1, 24'h200000, 8'h80, 0, 0, 24'hE00000);  // phase 0x200000
    add(1, 24'h200000, 8'h80, 0, 0, 24'h000000);  // phase 0x400000
    add(1, 24'h200000, 8'h80, 0, 0, 24'h200000);  // phase 0x600000
    add(1, 24'h200000, 8'h80, 0, 0, 24'h3FFFFF);  // phase 0x800000
    rst_exp2 = 24'hC00000;
`else
    // Continuous square tone
    add(1, PA, 8'h80, 0, 0, 24'h000000);  // IDLE->RUN strobe
    add(1, PA, 8'h80, 0, 0, PA);
    add(1, PA, 8'h80, 0, 0, PA);
    add(1, PA, 8'h80, 0, 0, NA);
    add(1, PA, 8'h80, 0, 0, NA);
    add(1, PA, 8'h80, 0, 0, PA);
    // Disable, idle, then beep 10/3
    add(0, PA, 8'h80, 0, 0, 24'h000000);
    add(0, PA, 8'h80, 0, 0, 24'h000000);
    add(1, PA, 8'h80, 10, 3, 24'h000000); // IDLE->RUN
    add(1, PA, 8'h80, 10, 3, PA);
    add(1, PA, 8'h80, 10, 3, PA);
    add(1, PA, 8'h80, 10, 3, NA);
    for (int i = 0; i < 7; i++) add(1, PA, 8'h80, 10, 3, 24'h000000);
    add(1, PA, 8'h80, 10, 3, PA);         // second beep restarts at +A
    add(1, PA, 8'h80, 10, 3, PA);
    // Disable mid-beep, then re-enable: restart from phase 0
    add(0, PA, 8'h80, 10, 3, 24'h000000);
    add(1, PA, 8'h80, 10, 3, 24'h000000); // IDLE->RUN
    add(1, PA, 8'h80, 10, 3, PA);
    add(1, PA, 8'h80, 10, 3, PA);
    add(1, PA, 8'h80, 10, 3, NA);
    // beep_on 0, period 5: silence
    add(1, PA, 8'h80, 5, 0, 24'h000000);
    add(1, PA, 8'h80, 5, 0, 24'h000000);
    add(1, PA, 8'h80, 5, 0, 24'h000000);
    // beep_on 20 >= period 5: continuous
    add(1, PA, 8'h80, 5, 20, PA);
    add(1, PA, 8'h80, 5, 20, NA);
    add(1, PA, 8'h80, 5, 20, NA);
    add(1, PA, 8'h80, 5, 20, PA);
    add(1, PA, 8'h80, 5, 20, PA);
    add(1, PA, 8'h80, 5, 20, PA);
    add(1, PA, 8'h80, 5, 20, NA);
    // amplitude 0
    add(1, PA, 8'h00, 0, 0, 24'h000000);
    add(1, PA, 8'h00, 0, 0, 24'h000000);
    rst_exp2 = PA;
`endif

    bus.enable_i = 0; bus.freq_word_i = '0; bus.amplitude_i = '0;
    bus.beep_period_i = '0; bus.beep_on_i = '0;

    // Reset state
    repeat (3) @(negedge clk_i);
    check("rst_sample_l", 32'(bus.sample_l_o), 32'd0);
    check("rst_sample_r", 32'(bus.sample_r_o), 32'd0);
    check("rst_ready", 32'(bus.sample_ready_o), 32'd0);

    // Strobe timing after release
    reset_i = 1'b0;
    wait_strobe(c);
    check("first_strobe_cycle", 32'(c), 32'(N));
    @(posedge clk_i); @(negedge clk_i);
    check("strobe_one_cycle", 32'(bus.sample_ready_o), 32'd0);
    wait_strobe(c);
    check("second_strobe_cycle", 32'(c + 1), 32'(N));

    // Table
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      drive(v);
      wait_strobe(c);
      check($sformatf("period_%0d", i), 32'(c), 32'(N));
      check($sformatf("sample_l_%0d", i), 32'(bus.sample_l_o), 32'(v.exp));
      check($sformatf("sample_r_%0d", i), 32'(bus.sample_r_o), 32'(v.exp));
    end

    // Mid-operation asynchronous reset
    bus.enable_i = 1; bus.freq_word_i = PA; bus.amplitude_i = 8'h80;
    bus.beep_period_i = 0; bus.beep_on_i = 0;
    wait_strobe(c);
    wait_strobe(c);
    n_cmp++;
    if (bus.sample_l_o === 24'd0) begin
      n_bad++;
      $display("FAIL pre_reset_nonzero: got %h, expected nonzero", bus.sample_l_o);
    end
    repeat (2) @(negedge clk_i);
    #2 reset_i = 1'b1;
    #1;
    check("async_rst_sample", 32'(bus.sample_l_o), 32'd0);
    check("async_rst_ready", 32'(bus.sample_ready_o), 32'd0);
    @(negedge clk_i);
    reset_i = 1'b0;
    wait_strobe(c);
    check("rst2_first_strobe", 32'(c), 32'(N));
    check("rst2_idle_run_sample", 32'(bus.sample_l_o), 32'd0);
    wait_strobe(c);
    check("rst2_first_run_sample", 32'(bus.sample_l_o), 32'(rst_exp2));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
